mbldcm_freq_ramp_ctrl: RTL
==========================

// Module: mbldcm_freq_ramp_ctrl
// PURPOSE
//  Ramp sequencer in front of the frequency-to-divider stage. Accepts target-frequency commands,
//  steps the current frequency toward the goal by iStep every pStepInterval cycles, and hands
//  each intermediate value over with a one-cycle latch pulse.
//  Waits for the divider stage's "reflected" handshake before the next step. Provides emergency stop
//  and a handshake-timeout error.
// PARAMETERS
//  pStepInterval  32'd1000  HOLD length in cycles between steps (min 1; 0 treated as 1)
//  pReflTimeout   32'd64    max cycles in WAIT_REFL before error (min 8; must exceed divider pipeline depth)
// PORTS
//  iClock            in   1   single clock, all logic rising-edge
//  iReset            in   1   synchronous, active-high reset
//  iCmdValid         in   1   new goal frequency offered
//  iCmdFreq          in   32  goal frequency (Hz); 0 = stop
//  oCmdReady         out  1   goal accepted on iCmdValid & oCmdReady
//  iStep             in   32  ramp step (Hz); 0 = jump directly to goal
//  iEStop            in   1   emergency stop, level, sampled every cycle
//  iClearErr         in   1   clears ERROR state
//  oLatchFreqTarget  out  1   one-cycle pulse: divider stage samples oFreqTarget
//  oFreqTarget       out  32  value to latch; driven = rFreqCur when not latching
//  iFreqReflected    in   1   divider stage has applied last latched value
//  oFreqCur          out  32  last latched frequency
//  oBusy             out  1   state != IDLE
//  oAtTarget         out  1   IDLE and rFreqCur == rFreqGoal
//  oError            out  1   state == ERROR
// BEHAVIOUR
//  Reset: state IDLE, rFreqCur=rFreqGoal=0, rEStopPend=0, oLatchFreqTarget=0, oFreqTarget=0,
//   oCmdReady=1, oBusy=0, oAtTarget=1, oError=0. Reset mid-ramp aborts immediately; no latch pulse.
//  States: IDLE, LATCH, WAIT_REFL, HOLD, ERROR.
//  oCmdReady = 1 in IDLE and HOLD, else 0. Accept writes rFreqGoal at the clock edge.
//  Next value (combinational, 33-bit math, no wrap):
//   rEStopPend=1 or iStep=0 -> goal; cur<goal -> min(cur+iStep, goal); cur>goal -> (cur-goal<=iStep) ? goal : cur-iStep.
//  IDLE: accept with iCmdFreq != rFreqCur -> LATCH next cycle; accept with equal value -> stay IDLE.
//  LATCH (exactly 1 cycle): oLatchFreqTarget=1, oFreqTarget=next; rFreqCur<=next; -> WAIT_REFL.
//  WAIT_REFL: wait-counter cleared on entry; iFreqReflected=1 -> (rEStopPend ? (cur!=0 ? LATCH : IDLE)
//   : HOLD). Counter reaching pReflTimeout without reflection -> ERROR.
//  HOLD: exactly pStepInterval cycles; then cur!=goal -> LATCH, else IDLE. Goal accepted during HOLD
//   applies to the next step; interval counter is not restarted.
//  iEStop=1 (any state except ERROR): rFreqGoal<=0, rEStopPend<=1; beats a simultaneous cmd accept.
//   IDLE/HOLD -> LATCH next cycle (HOLD abandoned); LATCH/WAIT_REFL complete normally first.
//   rEStopPend clears when a latch of 0 is reflected; while set, cmd accepts are ignored.
//  ERROR: oLatchFreqTarget=0, oCmdReady=0; leaves only on iClearErr -> IDLE, rFreqGoal<=rFreqCur.
//  Latency: accept edge N -> oLatchFreqTarget high during cycle N+1.
// TESTING
//  1 Reset held 3 cycles -> all outputs at reset values, oFreqCur=0, oAtTarget=1.
//  2 pStepInterval=4, iStep=1000, cmd 2500 -> latches 1000,2000,2500, 4-cycle HOLD between, then IDLE, oAtTarget=1.
//  3 From 2500, iStep=1000, cmd 0 -> latches 1500,500,0 (no underflow), oFreqCur=0.
//  4 iStep=0, cmd 40000 -> single latch of 40000, then HOLD -> IDLE.
//  5 Ramp to 5000 step 1000, iEStop pulse in HOLD after 2000 -> next cycle latch 0, no HOLD, IDLE; cmd during pend ignored.
//  6 iFreqReflected tied 0, pReflTimeout=16 -> oError=1 16 cycles after latch; iClearErr -> IDLE, oError=0.

Source files
------------

// File: rtl/mbldcm_freq_ramp_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mbldcm_freq_ramp_ctrl
// Description : Ramp sequencer ahead of the frequency-to-divider stage.
//               Steps the current frequency toward a commanded goal, one
//               latch pulse per intermediate value, waits for the divider's
//               reflected handshake, then holds before the next step.
//               Emergency stop ramps straight to 0; a missing handshake
//               raises a sticky error.
// Revision    : 1.0 - initial release
// ============================================================================
module mbldcm_freq_ramp_ctrl #(
  parameter logic [31:0] pStepInterval = 32'd1000,
  parameter logic [31:0] pReflTimeout  = 32'd64
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        iCmdValid,
  input  logic [31:0] iCmdFreq,
  output logic        oCmdReady,
  input  logic [31:0] iStep,
  input  logic        iEStop,
  input  logic        iClearErr,
  output logic        oLatchFreqTarget,
  output logic [31:0] oFreqTarget,
  input  logic        iFreqReflected,
  output logic [31:0] oFreqCur,
  output logic        oBusy,
  output logic        oAtTarget,
  output logic        oError
);

  // Clamp parameters to their legal minimums.
  localparam logic [31:0] cInterval = (pStepInterval == 32'd0) ? 32'd1 : pStepInterval;
  localparam logic [31:0] cTimeout  = (pReflTimeout < 32'd8) ? 32'd8 : pReflTimeout;
  // Timeout is measured from the latch pulse: the LATCH cycle plus
  // (cTimeout-1) WAIT_REFL cycles, so ERROR appears cTimeout cycles after it.
  localparam logic [31:0] cWaitLast = cTimeout - 32'd2;
  localparam logic [31:0] cHoldLast = cInterval - 32'd1;

  typedef enum logic [2:0] {
    sIdle     = 3'd0,
    sLatch    = 3'd1,
    sWaitRefl = 3'd2,
    sHold     = 3'd3,
    sError    = 3'd4
  } tState;

  tState       rState;
  tState       wStateNext;
  logic [31:0] rFreqCur;
  logic [31:0] rFreqGoal;
  logic        rEStopPend;
  logic [31:0] rWaitCnt;
  logic [31:0] rHoldCnt;

  logic        wReady;
  logic        wAccept;
  logic [31:0] wGoalEff;
  logic [31:0] wFreqNext;
  logic [32:0] wSum;
  logic [32:0] wGap;

  // Command handshake: ready in IDLE/HOLD; an E-stop or pending stop swallows the command.
  assign wReady   = (rState == sIdle) || (rState == sHold);
  assign wAccept  = iCmdValid && wReady && !iEStop && !rEStopPend;
  assign wGoalEff = wAccept ? iCmdFreq : rFreqGoal;

  // Next ramp value, computed with one guard bit so neither direction can wrap.
  always_comb begin
    wSum      = {1'b0, rFreqCur} + {1'b0, iStep};
    wGap      = {1'b0, rFreqCur} - {1'b0, rFreqGoal};
    wFreqNext = rFreqGoal;
    if (rEStopPend || (iStep == 32'd0)) begin
      wFreqNext = rFreqGoal;
    end else if (rFreqCur < rFreqGoal) begin
      wFreqNext = (wSum >= {1'b0, rFreqGoal}) ? rFreqGoal : wSum[31:0];
    end else if (rFreqCur > rFreqGoal) begin
      wFreqNext = (wGap <= {1'b0, iStep}) ? rFreqGoal : (rFreqCur - iStep);
    end
  end

  // State register.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rState <= sIdle;
    end else begin
      rState <= wStateNext;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    wStateNext       = rState;
    oCmdReady        = 1'b0;
    oLatchFreqTarget = 1'b0;
    oFreqTarget      = rFreqCur;
    case (rState)
      sIdle: begin
        oCmdReady = 1'b1;
        if (iEStop || rEStopPend) begin
          wStateNext = sLatch;
        end else if (wAccept && (iCmdFreq != rFreqCur)) begin
          wStateNext = sLatch;
        end
      end
      sLatch: begin
        oLatchFreqTarget = 1'b1;
        oFreqTarget      = wFreqNext;
        wStateNext       = sWaitRefl;
      end
      sWaitRefl: begin
        if (iFreqReflected) begin
          if (rEStopPend) begin
            wStateNext = (rFreqCur != 32'd0) ? sLatch : sIdle;
          end else begin
            wStateNext = sHold;
          end
        end else if (rWaitCnt == cWaitLast) begin
          wStateNext = sError;
        end
      end
      sHold: begin
        oCmdReady = 1'b1;
        if (iEStop || rEStopPend) begin
          wStateNext = sLatch;
        end else if (rHoldCnt == cHoldLast) begin
          wStateNext = (rFreqCur != wGoalEff) ? sLatch : sIdle;
        end
      end
      sError: begin
        if (iClearErr) begin
          wStateNext = sIdle;
        end
      end
      default: begin
        wStateNext = sIdle;
      end
    endcase
  end

  // Frequency registers, stop flag and the wait/hold counters.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      rFreqCur   <= 32'd0;
      rFreqGoal  <= 32'd0;
      rEStopPend <= 1'b0;
      rWaitCnt   <= 32'd0;
      rHoldCnt   <= 32'd0;
    end else begin
      if (iEStop && (rState != sError)) begin
        rFreqGoal  <= 32'd0;
        rEStopPend <= 1'b1;
      end else begin
        if (wAccept) begin
          rFreqGoal <= iCmdFreq;
        end
        // Stop completes once a latched 0 has been applied by the divider.
        if ((rState == sWaitRefl) && iFreqReflected && rEStopPend && (rFreqCur == 32'd0)) begin
          rEStopPend <= 1'b0;
        end
      end

      if (rState == sLatch) begin
        rFreqCur <= wFreqNext;
      end

      // Leaving ERROR re-anchors the goal at the last applied frequency.
      if ((rState == sError) && iClearErr) begin
        rFreqGoal  <= rFreqCur;
        rEStopPend <= 1'b0;
      end

      rWaitCnt <= (rState == sWaitRefl) ? (rWaitCnt + 32'd1) : 32'd0;
      rHoldCnt <= (rState == sHold) ? (rHoldCnt + 32'd1) : 32'd0;
    end
  end

  // Status outputs.
  assign oFreqCur  = rFreqCur;
  assign oBusy     = (rState != sIdle);
  assign oAtTarget = (rState == sIdle) && (rFreqCur == rFreqGoal);
  assign oError    = (rState == sError);

endmodule
`default_nettype wire
